// File: rtl/pkg_system_mdr.sv
// rtl/pkg_system_mdr.sv - shared MDR datapath widths and helper types
// Provides DATA_W, the operand payload type and an occupancy count type
// sized for the default pipeline depth.
package pkg_system_mdr;

    localparam int DATA_W    = 8;
    localparam int DEF_DEPTH = 2;

    typedef logic [DATA_W-1:0]                data_in_t;
    typedef logic [$clog2(DEF_DEPTH+1)-1:0]   pipe_cnt_t;

endpackage

// File: rtl/mdr_pipe_stage.sv
// rtl/mdr_pipe_stage.sv - one valid/data stage of the MDR elastic pipeline
// Ports: clk, rst (sync, active-high), flush (clears valid, data held),
//        in_valid/in_data/in_ready (upstream side),
//        out_valid/out_data/out_ready (downstream side).
module mdr_pipe_stage
    import pkg_system_mdr::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             in_ready
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // An empty stage always accepts, so bubbles collapse toward the output.
    assign in_ready = ~valid_q | out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (in_ready) begin
            valid_d = in_valid;
            // Bubbles never overwrite the held payload.
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/mdr_pipe_reg.sv
// rtl/mdr_pipe_reg.sv - DEPTH-stage elastic operand pipeline for the MDR datapath
// Ports: clk, rst (sync, active-high), i_flush (sync clear),
//        i_valid/o_ready/i_data (upstream), o_valid/i_ready/o_data (downstream),
//        o_count (occupied stages, only when MDR_PIPE_COUNT_EN is defined).
// Optional feature macro: MDR_PIPE_COUNT_EN.
module mdr_pipe_reg
    import pkg_system_mdr::*;
#(
    parameter int WIDTH = pkg_system_mdr::DATA_W,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
`ifdef MDR_PIPE_COUNT_EN
    output logic [CNT_W-1:0] o_count,
`endif
    output logic [WIDTH-1:0] o_data
);

    // Index k is the input side of stage k; index DEPTH is the block output.
    logic             vld [DEPTH+1];
    logic             rdy [DEPTH+1];
    logic [WIDTH-1:0] dat [DEPTH+1];

    assign vld[0]     = i_valid;
    assign dat[0]     = i_data;
    assign rdy[DEPTH] = i_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        mdr_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (i_flush),
            .in_valid  (vld[k]),
            .in_data   (dat[k]),
            .out_ready (rdy[k+1]),
            .out_valid (vld[k+1]),
            .out_data  (dat[k+1]),
            .in_ready  (rdy[k])
        );
    end

    assign o_ready = rdy[0] & ~i_flush;
    assign o_valid = vld[DEPTH];
    assign o_data  = dat[DEPTH];

`ifdef MDR_PIPE_COUNT_EN
    logic             in_xfer, out_xfer;
    logic [CNT_W-1:0] count_q, count_d;

    assign in_xfer  = i_valid & o_ready;
    assign out_xfer = o_valid & i_ready;

    always_comb begin
        count_d = count_q;
        if (i_flush) begin
            count_d = '0;
        end else if (in_xfer && !out_xfer && count_q != CNT_W'(DEPTH)) begin
            count_d = count_q + 1'b1;
        end else if (out_xfer && !in_xfer && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
`endif

endmodule
